ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. Sends one command byte to the keyboard, for example LED set 0xED, reset 0xFF or enable 0xF4. Drives the open-drain ps2_clk/ps2_data lines through output-enable (pull-low) signals. Sits beside the existing PS/2 receive logic; `busy` tells the receiver to ignore line activity while a transmission is in progress.

Parameters:
INHIBIT_CYCLES, 1600, px_clk cycles clock is held low before the request (100 us at 16 MHz).
TIMEOUT_CYCLES, 240000, max px_clk cycles from request to ack completion (15 ms at 16 MHz).
CNT_W, 18, width of the shared cycle counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
px_clk  in  1  system/pixel clock
clr  in  1  reset, asynchronous, active-high
tx_data  in  8  byte to send
tx_valid  in  1  request; byte accepted when tx_valid & tx_ready
tx_ready  out  1  high only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse: byte sent and acked
error  out  1  one-cycle pulse: timeout or missing ack
ps2_clk_in  in  1  raw PS/2 clock line
ps2_data_in  in  1  raw PS/2 data line
ps2_clk_oe  out  1  1 = pull clock low
ps2_data_oe  out  1  1 = pull data low

Behaviour:
- Reset (async, any state):
  - ps2_clk_oe = ps2_data_oe = 0 immediately, lines released.
  - done = error = busy = 0, tx_ready = 1, state = IDLE.
  - Counters, shift register and sync flops cleared; sync flops reset to 1 (idle line level).
- Inputs pass through a 2-flop synchroniser. A falling edge (fe) is synced clk going 1 to 0; it is seen 2–3 px_clk cycles after the pin changes.
- Accept:
  - In IDLE, tx_valid & tx_ready latches tx_data and computes odd parity p = ~^tx_data.
  - Next state INHIBIT; tx_valid is ignored outside IDLE.
- INHIBIT:
  - ps2_clk_oe = 1, data released; count INHIBIT_CYCLES.
  - Then ps2_data_oe = 1 (start bit), ps2_clk_oe = 0; go to REQ and clear the timeout counter.
- REQ/SHIFT: bit index 0..10. On each fe:
  - fe 1..8: drive data bit 0..7, LSB first.
  - fe 9: drive parity.
  - fe 10: release data (stop bit).
  - fe 11: sample synced data. Low means ack: go to WAIT_IDLE. High means no-ack: go to FAIL.
  - Driving a bit value v sets ps2_data_oe = ~v. The value is updated in the cycle after the fe is detected.
- WAIT_IDLE: wait until synced clk = 1 and data = 1. Then pulse done, go to IDLE.
- Timeout:
  - The timeout counter runs through REQ/SHIFT and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES goes to FAIL from either state.
  - A fe arriving in the same cycle as the timeout loses; the timeout wins.
- FAIL: release both lines, pulse error for one cycle, go to IDLE.
- Output pulses:
  - done and error are never high together.
  - tx_ready is low during the cycle done/error is high, and rises the cycle after.

Optional Feature:
PS2_TX_RETRY_EN:
- Defined:
  - On the first failure (no-ack or timeout), the block does not pulse error; it re-enters INHIBIT with the same latched byte.
  - A second failure pulses error.
  - A retry flag clears on accept and on done.
  - busy stays high across the retry.
- Undefined: the first failure pulses error; no retry logic is synthesised.

Decomposition:
- Package ps2_pkg:
  - State enum IDLE / INHIBIT / REQ / WAIT_IDLE / FAIL.
  - Command constants PS2_CMD_SET_LEDS = 8'hED, PS2_CMD_RESET = 8'hFF, PS2_CMD_ENABLE = 8'hF4.
  - Response constant PS2_RSP_ACK = 8'hFA.
  - Bit-count constant 11.
- Sub-module ps2_line_sync: 2-flop synchroniser plus falling-edge detect for clk and data. It is reusable by the receive path.

Test Plan:
1. Send 0xED with a device model clocking at 12.5 kHz that acks. Required:
   - clk held low for 1600 cycles, then start bit.
   - Bits 1,0,1,1,0,1,1,1, parity 1, stop released.
   - Data sampled low at fe 11, then done pulses once.
2. Send 0x07. Required: parity bit driven 0 (ps2_data_oe = 1 during the parity slot); done pulses.
3. Device never clocks after the request. Required:
   - error pulses exactly TIMEOUT_CYCLES after REQ entry.
   - Both oe = 0.
   - tx_ready returns high the next cycle.
4. Device clocks all 11 edges but leaves data high at fe 11. Required:
   - Without PS2_TX_RETRY_EN: error pulses, done stays 0.
   - With it: a second INHIBIT/REQ sequence carries the same byte; error pulses only after the second no-ack.
5. Assert clr mid-byte at fe 5. Required:
   - Both oe drop in the same cycle; busy = 0.
   - After clr is released, a new 0xFF is accepted and transmits correctly.
6. Hold tx_valid high with 0x12 during a transfer of 0xF4. Required: 0x12 is not accepted until tx_ready rises after done; then 0x12 is sent.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-TX FSM states, keyboard command/response bytes, frame size.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    WAIT_IDLE = 3'd3,
    FAIL      = 3'd4
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

  // Host frame: 8 data bits, parity, stop, then the device's ack slot.
  localparam int PS2_FRAME_BITS = 11;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS/2 clock and data pins, plus clock falling-edge detect.
// Latency: synced levels lag the pins by 2 px_clk; clk_fe is seen 2-3 cycles after the pin falls.
// Backpressure: none; free-running, sync flops reset to 1 (idle line level).
module ps2_line_sync (
  input  logic px_clk,
  input  logic clr,
  input  logic clk_pin,
  input  logic data_pin,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fe
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Double-register both pins and keep one extra clock sample for edge detection.
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], clk_pin};
      data_ff  <= {data_ff[0], data_pin};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_sync  = clk_ff[1];
  assign data_sync = data_ff[1];
  assign clk_fe    = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out byte+parity, check ack.
// Latency: INHIBIT_CYCLES + 11 device clocks + line-idle wait; done/error are 1-cycle pulses.
// Backpressure: tx_ready only in IDLE; optional retry-once on failure under PS2_TX_RETRY_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 1600,
  parameter int TIMEOUT_CYCLES = 240000,
  parameter int CNT_W          = 18
) (
  input  logic       px_clk,
  input  logic       clr,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  import ps2_pkg::*;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       ACK_IDX  = 4'(PS2_FRAME_BITS - 1);

  ps2_state_e       state;
  ps2_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [8:0]       frame;
  logic             clk_s;
  logic             data_s;
  logic             clk_fe;
  logic             accept;
  logic             inh_end;
  logic             timeout;
  logic             last_edge;

`ifdef PS2_TX_RETRY_EN
  logic             retry;
`endif

  ps2_line_sync u_sync (
    .px_clk    (px_clk),
    .clr       (clr),
    .clk_pin   (ps2_clk_in),
    .data_pin  (ps2_data_in),
    .clk_sync  (clk_s),
    .data_sync (data_s),
    .clk_fe    (clk_fe)
  );

  assign tx_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = tx_valid & tx_ready;
  assign ps2_clk_oe = (state == INHIBIT);
  // One counter serves both phases: inhibit length, then request-to-ack timeout.
  assign inh_end    = (cnt == INH_LAST);
  assign timeout    = (cnt == TO_LAST);
  assign last_edge  = (bit_idx == ACK_IDX);

  // State register.
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and pulse outputs; a timeout takes priority over a coincident clock edge.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    error     = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid) state_nxt = INHIBIT;
      end
      INHIBIT: begin
        if (inh_end) state_nxt = REQ;
      end
      REQ: begin
        if (timeout)                   state_nxt = FAIL;
        else if (clk_fe && last_edge)  state_nxt = data_s ? FAIL : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (timeout) begin
          state_nxt = FAIL;
        end else if (clk_s && data_s) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      FAIL: begin
`ifdef PS2_TX_RETRY_EN
        if (retry) begin
          error     = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = INHIBIT;
        end
`else
        error     = 1'b1;
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the frame, run the shared counter, and drive data after each clock fall.
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr) begin
      cnt         <= '0;
      bit_idx     <= '0;
      frame       <= '0;
      ps2_data_oe <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt         <= '0;
          bit_idx     <= '0;
          ps2_data_oe <= 1'b0;
          if (accept) frame <= {odd_parity(tx_data), tx_data};
        end
        INHIBIT: begin
          if (inh_end) begin
            // Start bit goes out as the clock is released; timeout starts from here.
            cnt         <= '0;
            bit_idx     <= '0;
            ps2_data_oe <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (state_nxt == FAIL) begin
            ps2_data_oe <= 1'b0;
          end else if (clk_fe) begin
            bit_idx <= bit_idx + 4'd1;
            // Edges 1..9 shift out data LSB first then parity; edge 10 releases for the stop bit.
            if (bit_idx < 4'd9) ps2_data_oe <= ~frame[bit_idx];
            else                ps2_data_oe <= 1'b0;
          end
        end
        WAIT_IDLE: begin
          cnt         <= cnt + CNT_W'(1);
          ps2_data_oe <= 1'b0;
        end
        default: begin
          cnt         <= '0;
          bit_idx     <= '0;
          ps2_data_oe <= 1'b0;
        end
      endcase
    end
  end

`ifdef PS2_TX_RETRY_EN
  // Retry flag: armed by the first failure, cleared by a new byte or a successful send.
  always_ff @(posedge px_clk or posedge clr) begin
    if (clr)                   retry <= 1'b0;
    else if (accept || done)   retry <= 1'b0;
    else if (state == FAIL)    retry <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 40;
  localparam int TO  = 2000;
  localparam int H   = 20;

  logic       px_clk = 1'b0;
  logic       clr;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done, error;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk, dev_data;

  int tests = 0;
  int fails = 0;

  // Open-drain lines: either side can pull low.
  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .CNT_W(12)) dut (
    .px_clk      (px_clk),
    .clr         (clr),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 px_clk = ~px_clk;

  typedef struct {
    logic [7:0] b;
    bit         ack;
    logic       par_oe;
    bit         exp_done;
    bit         exp_err;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_inhibit(output int n);
    int w;
    w = 0;
    n = 0;
    while (!ps2_clk_oe && w < 200) begin
      tick();
      w++;
    end
    check("inhibit_seen", ps2_clk_oe, 1);
    check("inhibit_data_rel", ps2_data_oe, 0);
    while (ps2_clk_oe && n < INH + 100) begin
      n++;
      tick();
    end
  endtask

  task automatic dev_fall();
    repeat (H) tick();
    dev_clk = 1'b0;
    repeat (H) tick();
  endtask

  // Inhibit, start bit, ten host-driven slots, then the 11th clock fall with ack/no-ack.
  task automatic run_frame(input logic [7:0] b, input logic par_oe, input bit ack);
    int   n;
    logic e;
    wait_inhibit(n);
    check("inhibit_len", n, INH);
    check("start_bit", ps2_data_oe, 1);
    check("clk_released", ps2_clk_oe, 0);
    for (int k = 1; k <= 10; k++) begin
      if (k <= 8)      e = ~b[k-1];
      else if (k == 9) e = par_oe;
      else             e = 1'b0;
      dev_fall();
      check($sformatf("slot%0d_b%0h", k, b), ps2_data_oe, e);
      dev_clk = 1'b1;
    end
    dev_data = ack ? 1'b0 : 1'b1;
    repeat (H) tick();
    dev_clk = 1'b0;
  endtask

  task automatic end_frame(input bit exp_done, input bit exp_err);
    int n;
    n = 0;
    while (n < 6 * H && !(done || error)) begin
      tick();
      n++;
      if (n == H) begin
        dev_clk  = 1'b1;
        dev_data = 1'b1;
      end
    end
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    check("end_pulse_seen", done | error, 1);
    check("done", done, exp_done);
    check("error", error, exp_err);
    check("ready_low_on_pulse", tx_ready, 0);
    check("oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
    tick();
    check("ready_rise", tx_ready, 1);
    check("pulse_once", done | error, 0);
  endtask

  // After a first no-ack the block must re-inhibit silently.
  task automatic retry_gap();
    int n;
    bit err_seen;
    n = 0;
    err_seen = 0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    while (!ps2_clk_oe && n < 6 * H) begin
      if (error) err_seen = 1;
      tick();
      n++;
    end
    check("retry_no_error", err_seen, 0);
    check("retry_busy", busy, 1);
    check("retry_reinhibit", ps2_clk_oe, 1);
  endtask

  initial begin
    int m;
    int exp_m;

    vecs[0] = '{PS2_CMD_SET_LEDS, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h07,            1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{PS2_CMD_ENABLE,   1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h80,            1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{8'h00,            1'b1, 1'b0, 1'b1, 1'b0};

    clr      = 1'b1;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) tick();
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_pulses", {done, error}, 0);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    clr = 1'b0;
    repeat (3) tick();

    // Table-driven frames.
    for (int i = 0; i < 5; i++) begin
      accept(vecs[i].b);
      check("busy_after_accept", busy, 1);
      run_frame(vecs[i].b, vecs[i].par_oe, vecs[i].ack);
`ifdef PS2_TX_RETRY_EN
      if (!vecs[i].ack) begin
        retry_gap();
        run_frame(vecs[i].b, vecs[i].par_oe, vecs[i].ack);
      end
`endif
      end_frame(vecs[i].exp_done, vecs[i].exp_err);
      repeat (5) tick();
    end

    // Device never clocks: timeout measured from first REQ cycle.
    accept(8'hF4);
    wait_inhibit(m);
    check("to_inhibit_len", m, INH);
`ifdef PS2_TX_RETRY_EN
    exp_m = 2 * TO + INH + 1;
`else
    exp_m = TO;
`endif
    m = 0;
    while (!error && m < 3 * TO) begin
      tick();
      m++;
    end
    check("timeout_cycles", m, exp_m);
    check("timeout_error", error, 1);
    check("timeout_no_done", done, 0);
    check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("timeout_ready_low", tx_ready, 0);
    tick();
    check("timeout_ready_rise", tx_ready, 1);
    repeat (5) tick();

    // Reset in the middle of the byte, on the 5th clock fall.
    accept(PS2_CMD_RESET);
    wait_inhibit(m);
    for (int k = 1; k <= 4; k++) begin
      dev_fall();
      check("pre_rst_slot", ps2_data_oe, 0);
      dev_clk = 1'b1;
    end
    repeat (H) tick();
    dev_clk = 1'b0;
    repeat (4) tick();
    check("pre_rst_busy", busy, 1);
    clr = 1'b1;
    #1;
    check("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", tx_ready, 1);
    dev_clk = 1'b1;
    repeat (3) tick();
    clr = 1'b0;
    repeat (3) tick();
    accept(PS2_CMD_RESET);
    run_frame(PS2_CMD_RESET, 1'b0, 1'b1);
    end_frame(1'b1, 1'b0);
    repeat (5) tick();

    // tx_valid held with a second byte while a transfer is active.
    accept(PS2_CMD_ENABLE);
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    run_frame(PS2_CMD_ENABLE, 1'b1, 1'b1);
    end_frame(1'b1, 1'b0);
    tick();
    tx_valid = 1'b0;
    check("held_accept", busy, 1);
    run_frame(8'h12, 1'b0, 1'b1);
    end_frame(1'b1, 1'b0);
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
